infer_scheduler: RTL and testbench

INFER_SCHEDULER -- requirements
Module: infer_scheduler

---
 rtl/infer_scheduler.sv | 152 +++++++++++++++
 tb/tb_infer_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infer_scheduler.sv
// infer_scheduler: admission control and result buffering around a fixed-latency
// inference datapath. Samples are registered onto x_dp, tracked through a
// LAT-bit token shift register, and their results are captured from y_dp into
// a DEPTH-entry FIFO. Admission is limited so that in-flight plus buffered
// samples never exceed DEPTH, which guarantees the FIFO can never overflow.
// Optional feature: define INFER_SCHED_PERF_EN to build the perf_acc /
// perf_stall counters; otherwise both outputs are tied to zero.
module infer_scheduler #(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 2,
  parameter int LAT     = 24,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITSIZE*N_IN-1:0]  x_in,
  output logic [BITSIZE*N_IN-1:0]  x_dp,
  input  logic [BITSIZE*N_OUT-1:0] y_dp,
  output logic                     prng_step,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITSIZE*N_OUT-1:0] y_out,
  input  logic                     flush,
  output logic                     busy,
  output logic [15:0]              perf_acc,
  output logic [15:0]              perf_stall
);

  localparam int XW = BITSIZE * N_IN;
  localparam int YW = BITSIZE * N_OUT;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [LAT-1:0]  tok_q, tok_d;
  logic [XW-1:0]   x_dp_q, x_dp_d;
  logic            prng_q, prng_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [YW-1:0]   fifo_mem [DEPTH];
  logic [IW-1:0]   inflight;
  logic            accept, push, pop, room;

  // Count the samples still travelling through the datapath.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + IW'(tok_q[i]);
    end
  end

  // Handshakes: in_ready depends only on state and occupancy, never on in_valid.
  assign room      = (int'(inflight) + int'(fifo_cnt_q)) < DEPTH;
  assign in_ready  = !reset && (state_q != DRAIN) && room;
  assign accept    = in_valid && in_ready;
  assign push      = tok_q[LAT-1];
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign y_out     = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign x_dp      = x_dp_q;
  assign prng_step = prng_q;

  // Next-state logic for the control FSM; flush overrides everything else.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (inflight == '0 && fifo_cnt_q == '0 && !accept) state_d = IDLE;
      DRAIN:   if (inflight == '0 && fifo_cnt_q == '0 && !flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = DRAIN;
  end

  // Datapath next values: sample register, token pipe, FIFO pointers and count.
  always_comb begin
    x_dp_d     = accept ? x_in : x_dp_q;
    prng_d     = accept;
    tok_d      = {tok_q[LAT-2:0], accept};
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      tok_q      <= '0;
      x_dp_q     <= '0;
      prng_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tok_q      <= tok_d;
      x_dp_q     <= x_dp_d;
      prng_q     <= prng_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Result storage: capture y_dp when a token leaves the pipe.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale contents are unreachable because fifo_cnt_q gates out_valid and y_out.
    if (push) fifo_mem[wr_ptr_q] <= y_dp;
  end

`ifdef INFER_SCHED_PERF_EN
  logic [15:0] perf_acc_q, perf_acc_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // Saturating counters for accepted samples and stalled offers.
  always_comb begin
    perf_acc_d   = perf_acc_q;
    perf_stall_d = perf_stall_q;
    if (accept && perf_acc_q != 16'hFFFF) perf_acc_d = perf_acc_q + 16'd1;
    if (in_valid && !in_ready && perf_stall_q != 16'hFFFF) perf_stall_d = perf_stall_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_acc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_acc_q   <= perf_acc_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_acc   = perf_acc_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_acc   = 16'd0;
  assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_infer_scheduler.sv
// Self-checking bench for infer_scheduler. The bench plays the inference
// datapath (y_dp is a fixed function of x_dp delayed by LAT cycles) and keeps a
// scoreboard: expected results are queued on every accept and compared on pop.
module tb_infer_scheduler;

  localparam int W     = 16;
  localparam int NI    = 10;
  localparam int NO    = 2;
  localparam int LAT   = 24;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            flush = 1'b0;
  logic [W*NI-1:0] x_in = '0;
  logic            in_ready, prng_step, out_valid, busy;
  logic [W*NI-1:0] x_dp;
  logic [W*NO-1:0] y_dp, y_out;
  logic [15:0]     perf_acc, perf_stall;

  int n_cmp = 0;
  int n_mis = 0;
  int n_acc = 0;
  int n_pop = 0;
  int model_acc = 0;
  int model_stall = 0;
  logic [W*NO-1:0] exp_q [$];
  logic [W*NO-1:0] exp_y;
  logic            hold_prev = 1'b0;
  logic [W*NO-1:0] prev_y = '0;
  logic [W*NI-1:0] pipe [LAT-1];

  infer_scheduler #(.BITSIZE(W), .N_IN(NI), .N_OUT(NO), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .x_dp(x_dp), .y_dp(y_dp), .prng_step(prng_step),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .flush(flush), .busy(busy), .perf_acc(perf_acc), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [W*NO-1:0] model_f(input logic [W*NI-1:0] x);
    logic [W-1:0] a, b;
    a = x[W-1:0] ^ x[2*W-1:W];
    b = x[W*NI-1 -: W] + 16'd3;
    return {b, a};
  endfunction

  // Datapath model: result of the sample presented on x_dp LAT cycles earlier.
  always @(posedge clk) begin
    pipe[0] <= x_dp;
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign y_dp = model_f(pipe[LAT-2]);

  // Monitor: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (reset) begin
      model_acc   = 0;
      model_stall = 0;
      hold_prev   = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        n_cmp++;
        if (y_out !== prev_y) begin
          n_mis++;
          $display("FAIL y_out_hold: got %h want %h", y_out, prev_y);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_y    = y_out;
      if (in_valid && in_ready) begin
        exp_q.push_back(model_f(x_in));
        n_acc++;
        model_acc++;
      end
      if (in_valid && !in_ready) model_stall++;
      if (out_valid && out_ready) begin
        n_pop++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_result: got %h want none", y_out);
        end else begin
          exp_y = exp_q.pop_front();
          if (y_out !== exp_y) begin
            n_mis++;
            $display("FAIL scoreboard_y_out: got %h want %h", y_out, exp_y);
          end
        end
      end
    end
  end

  task automatic rand_x();
    for (int i = 0; i < NI; i++) x_in[i*W +: W] = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 200) begin
      n_mis++;
      $display("FAIL %s_drain_timeout: got busy=%0b queued=%0d want idle", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (y_out !== '0) begin n_mis++; $display("FAIL rst_y_out: got %h want 0", y_out); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (x_dp !== '0) begin n_mis++; $display("FAIL rst_x_dp: got %h want 0", x_dp); end
    n_cmp++; if (prng_step !== 1'b0) begin n_mis++; $display("FAIL rst_prng: got %b want 0", prng_step); end
    n_cmp++; if (perf_acc !== 16'd0 || perf_stall !== 16'd0) begin
      n_mis++; $display("FAIL rst_perf: got %h/%h want 0/0", perf_acc, perf_stall);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    logic [W*NI-1:0] xs;
    int base_a, base_p;
    logic early;
    early = 1'b0;
    out_ready = 1'b1;
    base_a = n_acc;
    base_p = n_pop;
    @(negedge clk);
    rand_x();
    xs = x_in;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (n_acc - base_a !== 1) begin n_mis++; $display("FAIL single_accept: got %0d want 1", n_acc - base_a); end
    n_cmp++; if (prng_step !== 1'b1) begin n_mis++; $display("FAIL single_prng_hi: got %b want 1", prng_step); end
    n_cmp++; if (x_dp !== xs) begin n_mis++; $display("FAIL single_x_dp: got %h want %h", x_dp, xs); end
    @(negedge clk);
    n_cmp++; if (prng_step !== 1'b0) begin n_mis++; $display("FAIL single_prng_lo: got %b want 0", prng_step); end
    for (int k = 2; k <= LAT - 1; k++) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_mis++; $display("FAIL single_early_valid: got 1 want 0"); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL single_valid_lat: got %b want 1", out_valid); end
    n_cmp++; if (y_out !== model_f(xs)) begin n_mis++; $display("FAIL single_y_out: got %h want %h", y_out, model_f(xs)); end
    @(negedge clk);
    n_cmp++; if (n_pop - base_p !== 1 || out_valid !== 1'b0) begin
      n_mis++; $display("FAIL single_pop: got pops=%0d valid=%b want 1/0", n_pop - base_p, out_valid);
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL single_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base_a, base_p;
    out_ready = 1'b1;
    base_a = n_acc;
    base_p = n_pop;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= DEPTH) begin
        n_cmp++;
        if (n_acc - base_a !== k) begin n_mis++; $display("FAIL b2b_rate_%0d: got %0d want %0d", k, n_acc - base_a, k); end
      end
      if (k == DEPTH) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_mis++; $display("FAIL b2b_full_ready: got %b want 0", in_ready); end
      end
      in_valid = 1'b1;
      rand_x();
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle("b2b");
    n_cmp++; if (n_acc - base_a < 8) begin n_mis++; $display("FAIL b2b_throughput: got %0d want >=8", n_acc - base_a); end
    n_cmp++; if (n_pop - base_p !== n_acc - base_a) begin
      n_mis++; $display("FAIL b2b_pop_count: got %0d want %0d", n_pop - base_p, n_acc - base_a);
    end
  endtask

  task automatic test_backpressure();
    int base_a;
    logic [15:0] stall0;
    out_ready = 1'b0;
    base_a = n_acc;
    stall0 = perf_stall;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rand_x();
    end
    @(negedge clk);
    n_cmp++; if (n_acc - base_a !== DEPTH) begin n_mis++; $display("FAIL bp_accepts: got %0d want %0d", n_acc - base_a, DEPTH); end
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
`ifdef INFER_SCHED_PERF_EN
    n_cmp++; if (perf_stall - stall0 !== 16'd36) begin n_mis++; $display("FAIL bp_perf_stall: got %0d want 36", perf_stall - stall0); end
`else
    n_cmp++; if (perf_stall !== 16'd0) begin n_mis++; $display("FAIL bp_perf_stall_off: got %0d want 0", perf_stall); end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_reassert: got %b want 1", in_ready); end
    in_valid = 1'b0;
    wait_idle("bp");
  endtask

  task automatic test_flush();
    int base_a, base_p, k;
    logic bad;
    bad = 1'b0;
    out_ready = 1'b1;
    base_a = n_acc;
    base_p = n_pop;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rand_x();
      flush = (i == 2);
    end
    @(negedge clk);
    flush = 1'b0;
    rand_x();
    n_cmp++; if (n_acc - base_a !== 3) begin n_mis++; $display("FAIL flush_same_cycle_accept: got %0d want 3", n_acc - base_a); end
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_mis++; $display("FAIL flush_enter_drain: got busy=%b ready=%b want 1/0", busy, in_ready);
    end
    k = 0;
    while (n_pop - base_p < 3 && k < 100) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      k++;
    end
    in_valid = 1'b0;
    n_cmp++; if (k >= 100) begin n_mis++; $display("FAIL flush_timeout: got pops=%0d want 3", n_pop - base_p); end
    n_cmp++; if (bad !== 1'b0) begin n_mis++; $display("FAIL flush_hold: got ready/busy change want ready=0 busy=1"); end
    n_cmp++; if (n_acc - base_a !== 3) begin n_mis++; $display("FAIL flush_no_accept: got %0d want 3", n_acc - base_a); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL flush_idle: got busy=%b ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int base_p;
    logic stale;
    stale = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); in_valid = 1'b1; rand_x(); end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_mis++; $display("FAIL rm_buffered: got %b want 1", out_valid); end
    for (int i = 0; i < 2; i++) begin @(negedge clk); in_valid = 1'b1; rand_x(); end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++; if (out_valid !== 1'b0 || y_out !== '0) begin
      n_mis++; $display("FAIL rm_out_cleared: got valid=%b y=%h want 0/0", out_valid, y_out);
    end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_mis++; $display("FAIL rm_ctrl_cleared: got ready=%b busy=%b want 0/0", in_ready, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    base_p = n_pop;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rm_release_ready: got %b want 1", in_ready); end
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0 || n_pop != base_p) begin
      n_mis++; $display("FAIL rm_stale_result: got pops=%0d want 0", n_pop - base_p);
    end
    n_cmp++; if (perf_acc !== 16'd0) begin n_mis++; $display("FAIL rm_perf_cleared: got %0d want 0", perf_acc); end
  endtask

  task automatic test_perf_config();
    int base_a, k;
    out_ready = 1'b1;
    base_a = n_acc;
    k = 0;
    while (n_acc - base_a < 5 && k < 100) begin
      @(negedge clk);
      if (n_acc - base_a < 5) begin
        in_valid = 1'b1;
        rand_x();
      end
      k++;
    end
    in_valid = 1'b0;
    wait_idle("perf");
`ifdef INFER_SCHED_PERF_EN
    n_cmp++; if (perf_acc !== 16'd5) begin n_mis++; $display("FAIL perf_acc: got %0d want 5", perf_acc); end
    n_cmp++; if (perf_stall !== 16'(model_stall)) begin n_mis++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, model_stall); end
`else
    n_cmp++; if (perf_acc !== 16'd0) begin n_mis++; $display("FAIL perf_acc_off: got %0d want 0", perf_acc); end
    n_cmp++; if (perf_stall !== 16'd0) begin n_mis++; $display("FAIL perf_stall_off: got %0d want 0", perf_stall); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_perf_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
